// File: rtl/onehot_enc_pkg.sv
// Shared types and default sizes for the one-hot index serializer.
package onehot_enc_pkg;

    localparam int N_OUT_DEF = 4;
    localparam int N_IN_DEF  = 2 ** N_OUT_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DONE
    } state_e;

endpackage

// File: rtl/onehot_encoder_serializer_find_first_set.sv
// Combinational priority picker: index of the lowest (or highest) set bit of vec.
module find_first_set #(
    parameter int N_OUT      = 4,
    parameter bit HIGH_FIRST = 1'b0,
    localparam int N_IN      = 2 ** N_OUT
) (
    input  logic [N_IN-1:0]  vec,
    output logic [N_OUT-1:0] idx,
    output logic             found
);

    // The last match in scan order wins, so scan away from the preferred end.
    always_comb begin
        idx   = '0;
        found = |vec;
        if (HIGH_FIRST) begin
            for (int i = 0; i < N_IN; i++) begin
                if (vec[i]) idx = N_OUT'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (vec[i]) idx = N_OUT'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_encoder_serializer.sv
// Serializes a multi-hot request vector into binary indices on a valid/ready port.
module onehot_encoder_serializer
    import onehot_enc_pkg::*;
#(
    parameter int N_OUT      = N_OUT_DEF,
    parameter bit HIGH_FIRST = 1'b0,
    localparam int N_IN      = 2 ** N_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    input  logic             load,
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             empty
);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   pending_q, pending_d;
    logic [N_OUT-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              empty_q, empty_d;

    logic [N_IN-1:0]   clr_mask;
    logic [N_OUT-1:0]  ffs_idx;
    logic              ffs_found;
    logic              handshake;

    assign handshake = valid_q & out_ready;
    assign clr_mask  = N_IN'(1) << out_q;

    // Kept apart from the main next-state block so the picker sees a settled pending_d.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE && load && (|in)) begin
            pending_d = in;
        end else if (state_q == SERVE && handshake) begin
            pending_d = pending_q & ~clr_mask;
        end
    end

    find_first_set #(
        .N_OUT      (N_OUT),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_ffs (
        .vec   (pending_d),
        .idx   (ffs_idx),
        .found (ffs_found)
    );

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        empty_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (|in) begin
                        out_d   = ffs_idx;
                        valid_d = 1'b1;
                        state_d = SERVE;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (handshake) begin
                    if (ffs_found) begin
                        out_d = ffs_idx;
                    end else begin
                        out_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: pending is a plain register, not a memory array, so it is reset with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            empty_q   <= empty_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign empty     = empty_q;

endmodule
